// File: rtl/detect_sweep_scheduler_pkg.sv
// rtl/detect_sweep_scheduler_pkg.sv - shared frame layout and FSM encoding for the detect sweep scheduler
package detect_sweep_scheduler_pkg;

  typedef logic [4:0] widx_t;

  localparam int    FRAME_WORDS = 24;
  localparam int    H_WORDS     = 16;
  localparam int    Y_WORDS     = 8;
  localparam int    Y_OFFSET    = 16;
  localparam widx_t LAST_WORD   = widx_t'(FRAME_WORDS - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_WAIT_Q   = 3'd3;
  localparam logic [2:0] ST_WAIT_RES = 3'd4;

endpackage

// File: rtl/detect_sweep_scheduler_frame_pingpong_buf.sv
// rtl/detect_sweep_scheduler_frame_pingpong_buf.sv - two-bank frame store with write fill and read release
module detect_sweep_scheduler_frame_pingpong_buf
  import detect_sweep_scheduler_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_valid,
  input  logic [N-1:0] i_wr_r,
  input  logic [N-1:0] i_wr_i,
  output logic         o_wr_ready,
  input  widx_t        i_rd_idx_a,
  input  widx_t        i_rd_idx_b,
  output logic [N-1:0] o_rd_a_r,
  output logic [N-1:0] o_rd_a_i,
  output logic [N-1:0] o_rd_b_r,
  output logic [N-1:0] o_rd_b_i,
  output logic         o_rd_full,
  input  logic         i_release
);

  logic [2*N-1:0] r_mem [2][FRAME_WORDS];
  logic [1:0]     r_full;
  logic [1:0]     w_full_nxt;
  logic           r_wr_bank;
  logic           r_rd_bank;
  widx_t          r_wr_cnt;
  logic           w_wr_fire;
  logic           w_wr_last;

  assign o_wr_ready = !r_full[r_wr_bank];
  assign w_wr_fire  = i_wr_valid && o_wr_ready;
  assign w_wr_last  = w_wr_fire && (r_wr_cnt == LAST_WORD);
  assign o_rd_full  = r_full[r_rd_bank];

  assign {o_rd_a_r, o_rd_a_i} = r_mem[r_rd_bank][i_rd_idx_a];
  assign {o_rd_b_r, o_rd_b_i} = r_mem[r_rd_bank][i_rd_idx_b];

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_bank][r_wr_cnt] <= {i_wr_r, i_wr_i};
  end

  // Filling one bank and releasing the other can coincide; both flag updates apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (i_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 5'd1;
        end
      end
      if (i_release) r_rd_bank <= ~r_rd_bank;
    end
  end

endmodule

// File: rtl/detect_sweep_scheduler.sv
// rtl/detect_sweep_scheduler.sv - sweeps q_index over buffered H/Y frames and collects the detector decision
module detect_sweep_scheduler
  import detect_sweep_scheduler_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_Q   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r,
  input  logic [N-1:0] in_i,
  output logic         start_new_q,
  output logic [3:0]   q_index,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         q_done,
  input  logic         det_valid,
  input  logic [7:0]   det_b1,
  input  logic [3:0]   det_b2,
  output logic         out_valid,
  output logic [7:0]   out_b1,
  output logic [3:0]   out_b2,
  output logic         err,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [3:0]    r_q_cnt;
  logic [3:0]    r_ld_cnt;
  logic [TW-1:0] r_timer;
  logic          r_h_valid;
  logic [N-1:0]  r_h_r;
  logic [N-1:0]  r_h_i;
  logic          r_y_valid;
  logic [N-1:0]  r_y_r;
  logic [N-1:0]  r_y_i;
  logic          r_out_valid;
  logic [7:0]    r_out_b1;
  logic [3:0]    r_out_b2;

  logic          w_rd_full;
  logic          w_release;
  logic          w_timeout;
  logic          w_waiting;
  logic          w_expired;
  logic          w_q_last;
  logic          w_ld_last;
  logic          w_fetch;
  logic          w_y_fetch;
  logic [3:0]    w_fetch_idx;
  widx_t         w_h_idx;
  widx_t         w_y_idx;
  logic [N-1:0]  w_h_r;
  logic [N-1:0]  w_h_i;
  logic [N-1:0]  w_y_r;
  logic [N-1:0]  w_y_i;

  detect_sweep_scheduler_frame_pingpong_buf #(.N(N)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (in_valid),
    .i_wr_r     (in_r),
    .i_wr_i     (in_i),
    .o_wr_ready (in_ready),
    .i_rd_idx_a (w_h_idx),
    .i_rd_idx_b (w_y_idx),
    .o_rd_a_r   (w_h_r),
    .o_rd_a_i   (w_h_i),
    .o_rd_b_r   (w_y_r),
    .o_rd_b_i   (w_y_i),
    .o_rd_full  (w_rd_full),
    .i_release  (w_release)
  );

  assign w_waiting = (r_state == ST_WAIT_Q) || (r_state == ST_WAIT_RES);
  assign w_expired = w_waiting && (r_timer == TW'(TIMEOUT));
  assign w_q_last  = (r_q_cnt == 4'(NUM_Q - 1));
  assign w_ld_last = (r_ld_cnt == 4'(H_WORDS - 1));

  // Words are fetched one cycle ahead so the registered stream lines up with LOAD.
  assign w_fetch     = (r_state == ST_START) || ((r_state == ST_LOAD) && !w_ld_last);
  assign w_fetch_idx = (r_state == ST_START) ? 4'd0 : r_ld_cnt + 4'd1;
  assign w_y_fetch   = w_fetch && (w_fetch_idx < 4'(Y_WORDS));
  assign w_h_idx     = {1'b0, w_fetch_idx};
  assign w_y_idx     = widx_t'(Y_OFFSET) + {1'b0, w_fetch_idx};

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_rd_full) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_ld_last) w_state_nxt = ST_WAIT_Q;
      ST_WAIT_Q: begin
        if (q_done) begin
          w_state_nxt = w_q_last ? ST_WAIT_RES : ST_START;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RES: begin
        if (det_valid) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_q_cnt     <= '0;
      r_ld_cnt    <= '0;
      r_timer     <= '0;
      r_h_valid   <= 1'b0;
      r_h_r       <= '0;
      r_h_i       <= '0;
      r_y_valid   <= 1'b0;
      r_y_r       <= '0;
      r_y_i       <= '0;
      r_out_valid <= 1'b0;
      r_out_b1    <= '0;
      r_out_b2    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_IDLE) && (w_state_nxt == ST_START)) r_q_cnt <= '0;
      else if ((r_state == ST_WAIT_Q) && q_done && !w_q_last) r_q_cnt <= r_q_cnt + 4'd1;

      if (r_state == ST_START) r_ld_cnt <= '0;
      else if (r_state == ST_LOAD) r_ld_cnt <= r_ld_cnt + 4'd1;

      if (w_state_nxt != r_state) r_timer <= '0;
      else if (w_waiting) r_timer <= r_timer + 1'b1;

      r_h_valid <= w_fetch;
      r_h_r     <= w_fetch ? w_h_r : '0;
      r_h_i     <= w_fetch ? w_h_i : '0;
      r_y_valid <= w_y_fetch;
      r_y_r     <= w_y_fetch ? w_y_r : '0;
      r_y_i     <= w_y_fetch ? w_y_i : '0;

      r_out_valid <= (r_state == ST_WAIT_RES) && det_valid;
      if ((r_state == ST_WAIT_RES) && det_valid) begin
        r_out_b1 <= det_b1;
        r_out_b2 <= det_b2;
      end
    end
  end

  assign start_new_q = (r_state == ST_START);
  assign q_index     = (r_state == ST_START) ? r_q_cnt : 4'd0;
  assign H_in_valid  = r_h_valid;
  assign H_in_r      = r_h_r;
  assign H_in_i      = r_h_i;
  assign Y_in_valid  = r_y_valid;
  assign Y_in_r      = r_y_r;
  assign Y_in_i      = r_y_i;
  assign out_valid   = r_out_valid;
  assign out_b1      = r_out_b1;
  assign out_b2      = r_out_b2;
  assign err         = w_timeout;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_detect_sweep_scheduler.sv
// tb/tb_detect_sweep_scheduler.sv - directed bench for detect_sweep_scheduler
module tb_detect_sweep_scheduler;

  localparam int          N     = 32;
  localparam int          TO    = 1023;
  localparam logic [31:0] IMASK = 32'h5A5A0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_r = '0;
  logic [N-1:0] in_i = '0;
  logic         start_new_q;
  logic [3:0]   q_index;
  logic         H_in_valid;
  logic [N-1:0] H_in_r;
  logic [N-1:0] H_in_i;
  logic         Y_in_valid;
  logic [N-1:0] Y_in_r;
  logic [N-1:0] Y_in_i;
  logic         q_done = 1'b0;
  logic         det_valid = 1'b0;
  logic [7:0]   det_b1 = '0;
  logic [3:0]   det_b2 = '0;
  logic         out_valid;
  logic [7:0]   out_b1;
  logic [3:0]   out_b2;
  logic         err;
  logic         busy;

  typedef struct {
    int         base;
    logic [7:0] b1;
    logic [3:0] b2;
    int         drop_q;
    bit         inject;
  } frame_t;

  frame_t fq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int q_exp = 0, h_idx = 0, n_starts = 0, last_h_cyc = 0, n_out = 0, n_err = 0;
  int m_q = 0, m_h = 0, qd_cnt = 0, dv_cnt = 0;
  logic [31:0] exp_h, exp_y;

  detect_sweep_scheduler #(.N(N), .NUM_Q(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .start_new_q(start_new_q), .q_index(q_index),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .q_done(q_done), .det_valid(det_valid), .det_b1(det_b1), .det_b2(det_b2),
    .out_valid(out_valid), .out_b1(out_b1), .out_b2(out_b2), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Detector model: q_done 5 cycles after each LOAD, decision 10 cycles after the last q_done.
  always @(negedge clk) begin
    q_done    = 1'b0;
    det_valid = 1'b0;
    det_b1    = 8'h5A;
    det_b2    = 4'hC;
    if (rst) begin
      m_q = 0; m_h = 0; qd_cnt = 0; dv_cnt = 0;
    end else begin
      if (start_new_q) m_q = int'(q_index);
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0 && fq.size() > 0) begin
          det_valid = 1'b1;
          det_b1    = fq[0].b1;
          det_b2    = fq[0].b2;
        end
      end
      if (H_in_valid) begin
        m_h++;
        if (fq.size() > 0 && fq[0].inject && m_h == 4) q_done = 1'b1;
        if (m_h == 16) begin
          m_h = 0;
          if (fq.size() > 0 && m_q != fq[0].drop_q) qd_cnt = 5;
        end
      end else if (qd_cnt > 0) begin
        qd_cnt--;
        if (fq.size() > 0 && fq[0].inject && m_q == 2 && qd_cnt == 2) det_valid = 1'b1;
        if (qd_cnt == 0) begin
          q_done = 1'b1;
          if (m_q == 15) dv_cnt = 10;
        end
      end
    end
  end

  // Stream and result monitor.
  always @(negedge clk) begin
    if (rst) begin
      q_exp = 0; h_idx = 0; n_starts = 0;
    end else begin
      if (start_new_q) begin
        chk("q_index", q_index, q_exp);
        q_exp++; n_starts++; h_idx = 0;
      end
      if (H_in_valid) begin
        if (fq.size() == 0) chk("h_without_frame", H_in_valid, 0);
        else begin
          exp_h = 32'(fq[0].base + h_idx + 1);
          chk("h_r", H_in_r, exp_h);
          chk("h_i", H_in_i, exp_h ^ IMASK);
          if (h_idx < 8) begin
            exp_y = 32'(fq[0].base + 100 + h_idx);
            chk("y_valid", Y_in_valid, 1);
            chk("y_r", Y_in_r, exp_y);
            chk("y_i", Y_in_i, exp_y ^ IMASK);
          end else begin
            chk("y_valid_off", Y_in_valid, 0);
            chk("y_zero", Y_in_r, 0);
          end
        end
        h_idx++;
        if (h_idx == 16) last_h_cyc = cyc;
      end else if (Y_in_valid) begin
        chk("y_without_h", Y_in_valid, 0);
      end
      if (out_valid) begin
        n_out++;
        chk("out_expected", (fq.size() > 0 && fq[0].drop_q < 0), 1);
        if (fq.size() > 0) begin
          chk("out_b1", out_b1, fq[0].b1);
          chk("out_b2", out_b2, fq[0].b2);
          chk("starts_per_frame", n_starts, 16);
          void'(fq.pop_front());
        end
        q_exp = 0; n_starts = 0;
      end
      if (err) begin
        n_err++;
        chk("err_expected", (fq.size() > 0 && fq[0].drop_q >= 0), 1);
        chk("err_no_out", out_valid, 0);
        chk("err_latency", cyc - last_h_cyc, TO + 1);
        if (fq.size() > 0) begin
          chk("err_q", q_exp, fq[0].drop_q + 1);
          void'(fq.pop_front());
        end
        q_exp = 0; n_starts = 0;
      end
    end
  end

  task automatic push_frame(input int base, input logic [7:0] b1, input logic [3:0] b2,
                            input int drop_q, input bit inject);
    frame_t f;
    int w;
    int n;
    f.base = base; f.b1 = b1; f.b2 = b2; f.drop_q = drop_q; f.inject = inject;
    fq.push_back(f);
    for (int k = 0; k < 24; k++) begin
      w = (k < 16) ? base + k + 1 : base + 100 + k - 16;
      n = 0;
      while (!in_ready && n < 4000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 4000) chk("push_stall", in_ready, 1);
      in_valid = 1'b1;
      in_r     = w;
      in_i     = w ^ IMASK;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", fq.size(), 0);
  endtask

  initial begin
    logic prev;
    int   n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_new_q, 0);
    chk("rst_q_index", q_index, 0);
    chk("rst_h_valid", H_in_valid, 0);
    chk("rst_y_valid", Y_in_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_b1", out_b1, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    push_frame(0, 8'hA5, 4'h3, -1, 1'b0);
    drain(3000);
    chk("single_out_count", n_out, 1);

    push_frame(1000, 8'h11, 4'h1, -1, 1'b0);
    push_frame(2000, 8'h22, 4'h2, -1, 1'b0);
    chk("pp_ready_low", in_ready, 0);
    prev = in_ready;
    n = 0;
    while (!out_valid && n < 3000) begin
      prev = in_ready;
      @(negedge clk);
      n++;
    end
    chk("pp_out_seen", out_valid, 1);
    chk("pp_ready_before", prev, 0);
    chk("pp_ready_after", in_ready, 1);
    push_frame(3000, 8'h33, 4'h3, -1, 1'b0);
    drain(3000);
    chk("pp_out_count", n_out, 4);

    push_frame(4000, 8'h44, 4'h4, 7, 1'b0);
    push_frame(5000, 8'h55, 4'h5, -1, 1'b0);
    drain(6000);
    chk("to_err_count", n_err, 1);
    chk("to_out_count", n_out, 5);
    chk("to_ready", in_ready, 1);

    push_frame(6000, 8'h66, 4'h6, -1, 1'b1);
    drain(3000);
    chk("spur_out_count", n_out, 6);

    push_frame(7000, 8'h77, 4'h7, -1, 1'b0);
    n = 0;
    while (!(start_new_q && q_index == 4'd4) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_q4", start_new_q, 1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_start", start_new_q, 0);
    chk("arst_h_valid", H_in_valid, 0);
    chk("arst_h_r", H_in_r, 0);
    chk("arst_y_valid", Y_in_valid, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_b1", out_b1, 0);
    chk("arst_err", err, 0);
    fq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    push_frame(8000, 8'h88, 4'h8, -1, 1'b0);
    drain(3000);
    repeat (5) @(negedge clk);
    chk("final_out_count", n_out, 7);
    chk("final_err_count", n_err, 1);
    chk("hold_b1", out_b1, 8'h88);
    chk("hold_b2", out_b2, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/detect_sweep_scheduler.md
# detect_sweep_scheduler

Sequencer in front of the x_calculate detection datapath. It accepts complete channel/observation frames (16 H words followed by 8 Y words) into a ping-pong buffer. For each frame it sweeps q_index over NUM_Q candidates, replaying H and Y into the detector for every candidate. It then collects the detector's final b1/b2 decision and presents one result per frame.

## Interface
- N, 32, complex component width (two's complement, Q-format opaque to this block)
- NUM_Q, 16, candidates swept per frame (q_index = 0..NUM_Q-1)
- TIMEOUT, 1023, max cycles spent in WAIT_Q or WAIT_RES before abort
---
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  frame word valid
- in_ready  out  1  buffer can accept word
- in_r, in_i  in  N  frame word (words 0-15 H row-major, 16-19 Y rx1, 20-23 Y rx2)
- start_new_q  out  1  one-cycle start pulse to detector
- q_index  out  4  current candidate
- H_in_valid  out  1  H word strobe
- H_in_r, H_in_i  out  N  H word
- Y_in_valid  out  1  Y word strobe
- Y_in_r, Y_in_i  out  N  Y word
- q_done  in  1  detector finished current candidate
- det_valid  in  1  detector final decision valid
- det_b1  in  8, det_b2  in  4  detector decision
- out_valid  out  1  one-cycle result strobe
- out_b1  out  8, out_b2  out  4  held result
- err  out  1  one-cycle timeout/abort pulse
- busy  out  1  state != IDLE

## Operation
- Buffer: two banks × 24 words. Write side fills the bank selected by wr_bank with counter 0..23. On word 23 the bank is marked full and wr_bank toggles. in_ready = 1 while the target bank is not full.
- FSM: IDLE, START, LOAD, WAIT_Q, WAIT_RES.
- IDLE → START when rd_bank is full. q_cnt is cleared.
- START: start_new_q=1 and q_index=q_cnt for one cycle → LOAD.
- LOAD: 16 cycles, ld_cnt 0..15.
  - H_in_valid=1 every cycle with H[ld_cnt].
  - Y_in_valid=1 on ld_cnt 0..7 with Y[ld_cnt].
  - Exit → WAIT_Q after ld_cnt=15.
- WAIT_Q: wait for q_done.
  - If q_cnt<NUM_Q-1: q_cnt++ → START.
  - Else → WAIT_RES.
- WAIT_RES: on det_valid, capture det_b1/det_b2 into out_b1/out_b2. Pulse out_valid, clear the full flag of rd_bank, toggle rd_bank → IDLE.
- Timeout: a timer counts cycles in WAIT_Q/WAIT_RES and is cleared on state entry. When it reaches TIMEOUT: err=1 for one cycle, rd_bank is freed and toggled, no out_valid, → IDLE.
- Ignored inputs: q_done outside WAIT_Q and det_valid outside WAIT_RES have no effect.
- Same-cycle write/read completion: a write completing one bank and a read freeing the other in the same cycle both take effect.
- Reset mid-operation: all banks are marked empty. In-flight data is discarded and no err is issued.

## Timing
- Reset values: in_ready=1, every other output 0.
- Frame-word data outputs (H_*, Y_*) are registered. They are driven with valid in the same cycle and are 0 when not valid.
- Frame read to first start_new_q: 1 cycle after rd_bank becomes full (IDLE→START edge).
- start_new_q to first H_in_valid: 1 cycle. H stream is contiguous for 16 cycles.
- det_valid to out_valid: 1 cycle. out_b1/out_b2 hold until the next capture.
- Back-to-back: a second frame fully written during a sweep starts at the cycle after the first frame's out_valid+1 (IDLE one cycle).

## Structure
- Shared package: FSM state encoding, FRAME_WORDS=24, H_WORDS=16, Y_WORDS=8, Y_OFFSET=16.
- Sub-module frame_pingpong_buf:
  - two-bank storage, write counter, full flags, wr/rd bank pointers
  - combinational read port addressed by {rd_bank, word index}
  - release input
- The FSM stays in this block.

## Test plan
- Single frame: H word k = k+1 and Y word = 100+k; detector model pulses q_done 5 cycles after each LOAD and det_valid 10 cycles after the last q_done with b1=0xA5, b2=0x3.
  - Required: 16 start_new_q pulses with q_index 0..15.
  - Required: each LOAD carries H 1..16, and Y 100..107 on its first 8 cycles.
  - Required: out_valid once, out_b1=0xA5, out_b2=0x3.
- Ping-pong: push 3 frames back-to-back.
  - Required: in_ready drops after the 2nd frame and rises after frame 1 completes.
  - Required: three results appear in order.
- Timeout: q_done never asserted on q=7.
  - Required: err exactly TIMEOUT cycles after WAIT_Q entry, no out_valid, bank freed, next frame processed normally.
- Spurious strobes: q_done during LOAD and det_valid during WAIT_Q.
  - Required: no state change, no out_valid.
- Async reset asserted mid-LOAD of q=4.
  - Required: all outputs return to reset values immediately, in_ready=1, busy=0; the next frame starts at q_index 0.
